// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if: requester-side and UART-side handshake bundle for uart_tx_arbiter
interface uart_tx_arbiter_if #(
    parameter int NUM_REQ = 2
);
    logic [NUM_REQ*8-1:0] ipReqData;
    logic [NUM_REQ-1:0]   ipReqValid;
    logic [NUM_REQ-1:0]   ipReqLast;
    logic [NUM_REQ-1:0]   opReqReady;
    logic [NUM_REQ-1:0]   opGrant;
    logic [7:0]           opTxData;
    logic                 opTxSend;
    logic                 ipTxBusy;
    modport slave (
        input  ipReqData, ipReqValid, ipReqLast, ipTxBusy,
        output opReqReady, opGrant, opTxData, opTxSend
    );
    modport master (
        output ipReqData, ipReqValid, ipReqLast, ipTxBusy,
        input  opReqReady, opGrant, opTxData, opTxSend
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: message-granular round-robin sharing of one UART transmitter; ARB_TIMEOUT_EN adds forced release of a stalled grant
module uart_tx_arbiter #(
    parameter int NUM_REQ        = 2,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input logic             ipClk,
    input logic             ipnReset,
    uart_tx_arbiter_if.slave bus
);
    localparam int IW = $clog2(NUM_REQ);

    typedef enum logic [1:0] {IDLE, LOCK, SEND, DRAIN} state_t;

    state_t        state;
    logic [IW-1:0] ptr, gnt_idx, pick_idx, next_idx;
    logic          pick_ok, last_flag, timed_out;

    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("uart_tx_arbiter: NUM_REQ must be 2..8 and TIMEOUT_CYCLES >= 1");
    end

    assign next_idx = (int'(gnt_idx) == NUM_REQ - 1) ? '0 : gnt_idx + 1'b1;

    // first valid requester at or after the pointer; lowest offset is assigned last so it wins
    always_comb begin
        int j;
        pick_ok  = 1'b0;
        pick_idx = ptr;
        j        = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            j = int'(ptr) + k;
            if (j >= NUM_REQ) j -= NUM_REQ;
            if (bus.ipReqValid[IW'(j)]) begin
                pick_ok  = 1'b1;
                pick_idx = IW'(j);
            end
        end
    end

`ifdef ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] idle_cnt;

    assign timed_out = state == LOCK && !bus.ipReqValid[gnt_idx] && idle_cnt == CW'(TIMEOUT_CYCLES - 1);

    // counts cycles the owner leaves the transmitter unused inside a message
    always_ff @(posedge ipClk or negedge ipnReset) begin
        if (!ipnReset) idle_cnt <= '0;
        else if (state != LOCK || bus.ipReqValid[gnt_idx] || timed_out) idle_cnt <= '0;
        else idle_cnt <= idle_cnt + 1'b1;
    end
`else
    assign timed_out = 1'b0;
`endif

    // arbitration FSM; every output is registered here
    always_ff @(posedge ipClk or negedge ipnReset) begin
        if (!ipnReset) begin
            state          <= IDLE;
            ptr            <= '0;
            gnt_idx        <= '0;
            last_flag      <= 1'b0;
            bus.opGrant    <= '0;
            bus.opReqReady <= '0;
            bus.opTxData   <= 8'h00;
            bus.opTxSend   <= 1'b0;
        end else begin
            bus.opReqReady <= '0;
            case (state)
                IDLE: if (pick_ok) begin
                    gnt_idx     <= pick_idx;
                    bus.opGrant <= NUM_REQ'(1) << pick_idx;
                    state       <= LOCK;
                end
                LOCK: if (timed_out) begin
                    bus.opGrant <= '0;
                    ptr         <= next_idx;
                    state       <= IDLE;
                end else if (bus.ipReqValid[gnt_idx] && !bus.ipTxBusy) begin
                    bus.opTxData   <= bus.ipReqData[int'(gnt_idx)*8 +: 8];
                    last_flag      <= bus.ipReqLast[gnt_idx];
                    bus.opReqReady <= bus.opGrant;
                    bus.opTxSend   <= 1'b1;
                    state          <= SEND;
                end
                SEND: if (bus.ipTxBusy) begin
                    bus.opTxSend <= 1'b0;
                    state        <= DRAIN;
                end
                DRAIN: if (!bus.ipTxBusy) begin
                    if (last_flag) begin
                        bus.opGrant <= '0;
                        ptr         <= next_idx;
                        state       <= IDLE;
                    end else begin
                        state <= LOCK;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed checks of uart_tx_arbiter against a simple UART busy model
module tb_uart_tx_arbiter;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    int         errors = 0;
    int         checks = 0;
    int         busy_len = 4;
    int         busy_cnt;
    int         cyc = 0;
    logic [8:0] q0[$];
    logic [8:0] q1[$];
    logic [1:0] en = 2'b11;
    logic [7:0] log_d[16];
    logic [1:0] log_g[16];
    int         log_n = 0;
    int         ready_cnt[2];
    logic       prev_send = 1'b0;

    uart_tx_arbiter_if #(.NUM_REQ(2)) bus ();

    uart_tx_arbiter #(.NUM_REQ(2), .TIMEOUT_CYCLES(16)) dut (
        .ipClk(clk),
        .ipnReset(rst_n),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // UART model: busy rises the edge after a send is seen, lasts busy_len cycles
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) busy_cnt <= 0;
        else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
        else if (bus.opTxSend) busy_cnt <= busy_len;
    end
    assign bus.ipTxBusy = busy_cnt != 0;

    task automatic drive();
        bus.ipReqValid = {en[1] && q1.size() != 0, en[0] && q0.size() != 0};
        bus.ipReqData  = {q1.size() != 0 ? q1[0][7:0] : 8'h00, q0.size() != 0 ? q0[0][7:0] : 8'h00};
        bus.ipReqLast  = {q1.size() != 0 && q1[0][8], q0.size() != 0 && q0[0][8]};
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
        if (bus.opReqReady[0]) begin
            ready_cnt[0]++;
            if (q0.size() != 0) void'(q0.pop_front());
        end
        if (bus.opReqReady[1]) begin
            ready_cnt[1]++;
            if (q1.size() != 0) void'(q1.pop_front());
        end
        if (bus.opTxSend && !prev_send && log_n < 16) begin
            log_d[log_n] = bus.opTxData;
            log_g[log_n] = bus.opGrant;
            log_n++;
        end
        prev_send = bus.opTxSend;
        drive();
    endtask

    task automatic clear();
        for (int i = 0; i < 16; i++) begin
            log_d[i] = 8'hxx;
            log_g[i] = 2'bxx;
        end
        log_n = 0;
        ready_cnt[0] = 0;
        ready_cnt[1] = 0;
    endtask

    function automatic bit idle_now();
        return q0.size() == 0 && q1.size() == 0 && bus.opGrant == 2'b00 && !bus.ipTxBusy;
    endfunction

    task automatic wait_idle(input int limit, output bit done);
        done = 0;
        for (int t = 0; t < limit && !done; t++) begin
            tick();
            done = idle_now();
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        q0.delete();
        q1.delete();
        en = 2'b11;
        drive();
        tick();
        tick();
        checks++; if (bus.opGrant !== 2'b00) begin errors++; $display("FAIL reset_grant: got %b want 00", bus.opGrant); end
        checks++; if (bus.opReqReady !== 2'b00) begin errors++; $display("FAIL reset_ready: got %b want 00", bus.opReqReady); end
        checks++; if (bus.opTxData !== 8'h00) begin errors++; $display("FAIL reset_data: got %h want 00", bus.opTxData); end
        checks++; if (bus.opTxSend !== 1'b0) begin errors++; $display("FAIL reset_send: got %b want 0", bus.opTxSend); end
        rst_n = 1'b1;
    endtask

    task automatic test_two_byte();
        int  fall_t = -1;
        int  zero_t = -1;
        bit  seen_busy = 0;
        bit  grant_bad = 0;
        bit  done = 0;
        busy_len = 10;
        clear();
        q0.push_back(9'h041);
        q0.push_back(9'h142);
        drive();
        for (int t = 0; t < 200 && !done; t++) begin
            tick();
            if (log_n == 2 && bus.ipTxBusy) seen_busy = 1;
            if (seen_busy && !bus.ipTxBusy && fall_t < 0) fall_t = t;
            else if (fall_t >= 0 && bus.opGrant == 2'b00) begin zero_t = t; done = 1; end
            if (!done && bus.opGrant != 2'b01 && (log_n != 0 || bus.opGrant != 2'b00)) grant_bad = 1;
        end
        checks++; if (!done) begin errors++; $display("FAIL ab_done: got %0b want 1", done); end
        checks++; if (log_n != 2) begin errors++; $display("FAIL ab_count: got %0d want 2", log_n); end
        checks++; if (log_d[0] !== 8'h41) begin errors++; $display("FAIL ab_byte0: got %h want 41", log_d[0]); end
        checks++; if (log_d[1] !== 8'h42) begin errors++; $display("FAIL ab_byte1: got %h want 42", log_d[1]); end
        checks++; if (log_g[0] !== 2'b01 || log_g[1] !== 2'b01) begin errors++; $display("FAIL ab_grant: got %b %b want 01 01", log_g[0], log_g[1]); end
        checks++; if (grant_bad) begin errors++; $display("FAIL ab_grant_held: got 1 want 0"); end
        checks++; if (zero_t - fall_t != 1) begin errors++; $display("FAIL ab_release: got %0d want 1", zero_t - fall_t); end
        checks++; if (ready_cnt[0] != 2) begin errors++; $display("FAIL ab_ready: got %0d want 2", ready_cnt[0]); end
    endtask

    task automatic test_both_from_reset();
        logic [7:0] ed[7] = '{8'h10, 8'h11, 8'h12, 8'h20, 8'h21, 8'h22, 8'h13};
        logic [1:0] eg[7] = '{2'b01, 2'b01, 2'b01, 2'b10, 2'b10, 2'b10, 2'b01};
        bit done;
        rst_n = 1'b0;
        busy_len = 4;
        clear();
        q0 = '{9'h010, 9'h011, 9'h112, 9'h113};
        q1 = '{9'h020, 9'h021, 9'h122};
        drive();
        tick();
        rst_n = 1'b1;
        wait_idle(400, done);
        checks++; if (!done) begin errors++; $display("FAIL both_done: got %0b want 1", done); end
        checks++; if (log_n != 7) begin errors++; $display("FAIL both_count: got %0d want 7", log_n); end
        for (int k = 0; k < 7; k++) begin
            checks++;
            if (log_d[k] !== ed[k] || log_g[k] !== eg[k]) begin
                errors++;
                $display("FAIL both_byte%0d: got %h/%b want %h/%b", k, log_d[k], log_g[k], ed[k], eg[k]);
            end
        end
        checks++; if (ready_cnt[0] != 4 || ready_cnt[1] != 3) begin errors++; $display("FAIL both_ready: got %0d/%0d want 4/3", ready_cnt[0], ready_cnt[1]); end
    endtask

    task automatic test_blocked();
        logic [7:0] ed[5] = '{8'h30, 8'h31, 8'h32, 8'h40, 8'h41};
        logic [1:0] eg[5] = '{2'b10, 2'b10, 2'b10, 2'b01, 2'b01};
        bit done;
        clear();
        en = 2'b10;
        q1 = '{9'h030, 9'h031, 9'h132};
        q0 = '{9'h040, 9'h141};
        drive();
        for (int t = 0; t < 50 && ready_cnt[1] == 0; t++) tick();
        en = 2'b11;
        drive();
        wait_idle(300, done);
        checks++; if (!done) begin errors++; $display("FAIL blk_done: got %0b want 1", done); end
        checks++; if (log_n != 5) begin errors++; $display("FAIL blk_count: got %0d want 5", log_n); end
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (log_d[k] !== ed[k] || log_g[k] !== eg[k]) begin
                errors++;
                $display("FAIL blk_byte%0d: got %h/%b want %h/%b", k, log_d[k], log_g[k], ed[k], eg[k]);
            end
        end
    endtask

    task automatic test_single_byte();
        bit done;
        int lat;
        clear();
        for (int r = 0; r < 4; r++) begin
            q1.push_back(9'h170 + 9'(r));
            drive();
            lat = 0;
            for (int t = 1; t <= 10 && lat == 0; t++) begin
                tick();
                if (bus.opTxSend) lat = t;
            end
            checks++; if (lat != 2) begin errors++; $display("FAIL single_lat%0d: got %0d want 2", r, lat); end
            wait_idle(100, done);
            checks++; if (!done) begin errors++; $display("FAIL single_done%0d: got %0b want 1", r, done); end
        end
        checks++; if (log_n != 4) begin errors++; $display("FAIL single_count: got %0d want 4", log_n); end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (log_d[k] !== 8'h70 + 8'(k) || log_g[k] !== 2'b10) begin
                errors++;
                $display("FAIL single_byte%0d: got %h/%b want %h/10", k, log_d[k], log_g[k], 8'h70 + 8'(k));
            end
        end
    endtask

    task automatic test_reset_in_send();
        bit done;
        clear();
        q1.push_back(9'h1A5);
        drive();
        for (int t = 0; t < 10 && !bus.opTxSend; t++) tick();
        checks++; if (bus.opTxSend !== 1'b1) begin errors++; $display("FAIL rs_reach_send: got %b want 1", bus.opTxSend); end
        #1 rst_n = 1'b0;
        #1;
        checks++; if (bus.opGrant !== 2'b00) begin errors++; $display("FAIL rs_grant: got %b want 00", bus.opGrant); end
        checks++; if (bus.opTxSend !== 1'b0) begin errors++; $display("FAIL rs_send: got %b want 0", bus.opTxSend); end
        checks++; if (bus.opTxData !== 8'h00) begin errors++; $display("FAIL rs_data: got %h want 00", bus.opTxData); end
        checks++; if (bus.opReqReady !== 2'b00) begin errors++; $display("FAIL rs_ready: got %b want 00", bus.opReqReady); end
        q0.delete();
        q1.delete();
        q0.push_back(9'h1B0);
        q1.push_back(9'h1B1);
        drive();
        tick();
        clear();
        rst_n = 1'b1;
        tick();
        checks++; if (bus.opGrant !== 2'b01) begin errors++; $display("FAIL rs_first_grant: got %b want 01", bus.opGrant); end
        wait_idle(200, done);
        checks++; if (!done || log_n != 2) begin errors++; $display("FAIL rs_count: got %0d want 2", log_n); end
        checks++; if (log_d[0] !== 8'hB0 || log_g[0] !== 2'b01) begin errors++; $display("FAIL rs_byte0: got %h/%b want b0/01", log_d[0], log_g[0]); end
        checks++; if (log_d[1] !== 8'hB1 || log_g[1] !== 2'b10) begin errors++; $display("FAIL rs_byte1: got %h/%b want b1/10", log_d[1], log_g[1]); end
    endtask

    task automatic test_timeout();
        int fall_c = -1;
        int zero_c = -1;
        bit seen_busy = 0;
        rst_n = 1'b0;
        busy_len = 4;
        clear();
        q0 = '{9'h050};
        q1 = '{9'h160};
        drive();
        tick();
        rst_n = 1'b1;
        for (int t = 0; t < 60 && fall_c < 0; t++) begin
            tick();
            if (log_n == 1 && bus.ipTxBusy) seen_busy = 1;
            if (seen_busy && !bus.ipTxBusy) fall_c = cyc;
        end
        checks++; if (fall_c < 0) begin errors++; $display("FAIL to_first_byte: got no busy fall want one"); end
        for (int t = 0; t < 100; t++) begin
            tick();
            if (zero_c < 0 && bus.opGrant == 2'b00) zero_c = cyc;
        end
`ifdef ARB_TIMEOUT_EN
        checks++; if (zero_c - fall_c != 17) begin errors++; $display("FAIL to_release: got %0d want 17", zero_c - fall_c); end
        checks++; if (log_n != 2 || log_d[1] !== 8'h60 || log_g[1] !== 2'b10) begin errors++; $display("FAIL to_req1: got %0d %h/%b want 2 60/10", log_n, log_d[1], log_g[1]); end
`else
        checks++; if (bus.opGrant !== 2'b01) begin errors++; $display("FAIL to_hold_grant: got %b want 01", bus.opGrant); end
        checks++; if (log_n != 1 || zero_c >= 0) begin errors++; $display("FAIL to_req1_blocked: got %0d sends want 1", log_n); end
`endif
        rst_n = 1'b0;
        q0.delete();
        q1.delete();
        drive();
        tick();
    endtask

    initial begin
        clear();
        drive();
        test_reset();
        test_two_byte();
        test_both_from_reset();
        test_blocked();
        test_single_byte();
        test_reset_in_send();
        test_timeout();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
